// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered ALU datapath between two requesters.
// One operation in flight; results are returned on the response port of the requester that issued it.
module alu_arbiter #(
    parameter int unsigned W       = 4,
    parameter int unsigned LATENCY = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req0_c,
    input  logic [2:0]   req0_s,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic         req1_c,
    input  logic [2:0]   req1_s,
    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic [W-1:0] rsp0_o,
    output logic         rsp0_cout,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [W-1:0] rsp1_o,
    output logic         rsp1_cout,
    output logic         alu_enable,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic         alu_c,
    output logic [2:0]   alu_s,
    input  logic [W-1:0] alu_o,
    input  logic         alu_cout,
    output logic         busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] EXEC  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam int unsigned CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;

    logic [1:0]   state;
    logic         last_grant;
    logic         op_id;
    logic [CW-1:0] cnt;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_c;
    logic [2:0]   op_s;

    logic         any_valid;
    logic         grant;
    logic         accept;
    logic         dp_on;
    logic         rsp_on;
    logic         rsp_take;

    // On a tie the requester not served last wins; otherwise the lone valid one.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else begin
            grant = req1_valid;
        end
        accept     = (state == IDLE) && !reset && any_valid;
        req0_ready = accept && !grant;
        req1_ready = accept && grant;
    end

    always_comb begin
        dp_on      = (state == ISSUE) || (state == EXEC);
        alu_enable = dp_on;
        alu_a      = dp_on ? op_a : '0;
        alu_b      = dp_on ? op_b : '0;
        alu_c      = dp_on ? op_c : 1'b0;
        alu_s      = dp_on ? op_s : '0;
    end

    always_comb begin
        rsp_on     = (state == RESP) && !reset;
        rsp0_valid = rsp_on && !op_id;
        rsp1_valid = rsp_on && op_id;
        rsp0_o     = rsp0_valid ? alu_o : '0;
        rsp0_cout  = rsp0_valid ? alu_cout : 1'b0;
        rsp1_o     = rsp1_valid ? alu_o : '0;
        rsp1_cout  = rsp1_valid ? alu_cout : 1'b0;
        rsp_take   = op_id ? rsp1_ready : rsp0_ready;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            op_id      <= 1'b0;
            cnt        <= '0;
            op_a       <= '0;
            op_b       <= '0;
            op_c       <= 1'b0;
            op_s       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        op_a       <= grant ? req1_a : req0_a;
                        op_b       <= grant ? req1_b : req0_b;
                        op_c       <= grant ? req1_c : req0_c;
                        op_s       <= grant ? req1_s : req0_s;
                        op_id      <= grant;
                        last_grant <= grant;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= CW'(LATENCY - 2);
                    state <= EXEC;
                end
                EXEC: begin
                    if (cnt == '0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_take) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed protocol scenarios plus a randomized run against a
// transaction-level reference, with behavioural datapath models for LATENCY 2 and 3.
module tb_alu_arbiter;

    localparam int unsigned W = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic         req0_valid, req0_ready, req0_c, req1_valid, req1_ready, req1_c;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]   req0_s, req1_s;
    logic         rsp0_valid, rsp0_ready, rsp0_cout, rsp1_valid, rsp1_ready, rsp1_cout;
    logic [W-1:0] rsp0_o, rsp1_o;
    logic         alu_enable, alu_c, alu_cout, busy;
    logic [W-1:0] alu_a, alu_b, alu_o;
    logic [2:0]   alu_s;

    logic         l3_valid, l3_ready, l3_r1rdy, l3_rsp0_valid, l3_rsp0_cout, l3_rsp1_valid, l3_rsp1_cout;
    logic [W-1:0] l3_rsp0_o, l3_rsp1_o, l3_a, l3_b, l3_o;
    logic         l3_en, l3_c, l3_cout, l3_busy;
    logic [2:0]   l3_s;

    alu_arbiter #(.W(W), .LATENCY(2)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_c(req0_c), .req0_s(req0_s),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_c(req1_c), .req1_s(req1_s),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_o(rsp0_o), .rsp0_cout(rsp0_cout),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_o(rsp1_o), .rsp1_cout(rsp1_cout),
        .alu_enable(alu_enable), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_s(alu_s),
        .alu_o(alu_o), .alu_cout(alu_cout), .busy(busy)
    );

    alu_arbiter #(.W(W), .LATENCY(3)) dut3 (
        .clk(clk), .reset(reset),
        .req0_valid(l3_valid), .req0_ready(l3_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_c(req0_c), .req0_s(req0_s),
        .req1_valid(1'b0), .req1_ready(l3_r1rdy), .req1_a('0), .req1_b('0),
        .req1_c(1'b0), .req1_s(3'b000),
        .rsp0_valid(l3_rsp0_valid), .rsp0_ready(1'b1), .rsp0_o(l3_rsp0_o), .rsp0_cout(l3_rsp0_cout),
        .rsp1_valid(l3_rsp1_valid), .rsp1_ready(1'b1), .rsp1_o(l3_rsp1_o), .rsp1_cout(l3_rsp1_cout),
        .alu_enable(l3_en), .alu_a(l3_a), .alu_b(l3_b), .alu_c(l3_c), .alu_s(l3_s),
        .alu_o(l3_o), .alu_cout(l3_cout), .busy(l3_busy)
    );

    // Behavioural ALU: returns {cout, o}.
    function automatic logic [4:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic c, input logic [2:0] s);
        case (s)
            3'd0:    return {1'b0, a} + {1'b0, b} + {4'd0, c};
            3'd1:    return {1'b0, a} - {1'b0, b} - {4'd0, c};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            3'd5:    return {a[3], a[2:0], c};
            3'd6:    return {a[0], c, a[3:1]};
            default: return {1'b0, ~a};
        endcase
    endfunction

    // Datapath models: input regs, then LATENCY-1 result stages; S is read unregistered.
    logic [W-1:0] dp_a, dp_b, q_a, q_b;
    logic         dp_c, q_c;
    logic [4:0]   dp_res, q_s1, q_s2;
    always @(posedge clk) begin
        if (reset) begin
            dp_a <= '0; dp_b <= '0; dp_c <= 1'b0; dp_res <= '0;
        end else if (alu_enable) begin
            dp_a <= alu_a; dp_b <= alu_b; dp_c <= alu_c;
            dp_res <= alu_f(dp_a, dp_b, dp_c, alu_s);
        end
    end
    assign {alu_cout, alu_o} = dp_res;

    always @(posedge clk) begin
        if (reset) begin
            q_a <= '0; q_b <= '0; q_c <= 1'b0; q_s1 <= '0; q_s2 <= '0;
        end else if (l3_en) begin
            q_a <= l3_a; q_b <= l3_b; q_c <= l3_c;
            q_s1 <= alu_f(q_a, q_b, q_c, l3_s);
            q_s2 <= q_s1;
        end
    end
    assign {l3_cout, l3_o} = q_s2;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // Waits (bounded) for a request handshake, checks grant, datapath drive during
    // ISSUE/EXEC, and the tagged response; returns at the first response cycle.
    task automatic expect_op(input string tag, input int exp_id, input bit drop,
                             output int hs, output logic [4:0] res);
        int got;
        logic [W-1:0] a_lat;
        logic [2:0]   s_lat;
        got = -1;
        hs  = 0;
        res = '0;
        a_lat = '0;
        s_lat = '0;
        for (int i = 0; i < 12 && got < 0; i++) begin
            settle();
            if (req0_ready || req1_ready) begin
                chk({tag, "_one_ready"}, {31'd0, req0_ready & req1_ready}, 32'd0);
                got   = req1_ready ? 1 : 0;
                a_lat = got ? req1_a : req0_a;
                s_lat = got ? req1_s : req0_s;
                res   = got ? alu_f(req1_a, req1_b, req1_c, req1_s)
                            : alu_f(req0_a, req0_b, req0_c, req0_s);
                hs    = cyc;
            end
            tick();
        end
        chk({tag, "_grant"}, got, exp_id);
        if (got < 0) return;
        if (drop) begin
            if (got == 1) begin
                req1_valid = 1'b0; req1_a = ~req1_a; req1_s = ~req1_s; req1_b = W'($urandom);
            end else begin
                req0_valid = 1'b0; req0_a = ~req0_a; req0_s = ~req0_s; req0_b = W'($urandom);
            end
        end
        for (int i = 0; i < 2; i++) begin
            settle();
            chk({tag, "_exec_en"}, {31'd0, alu_enable}, 32'd1);
            chk({tag, "_exec_s"}, {29'd0, alu_s}, {29'd0, s_lat});
            chk({tag, "_exec_a"}, {28'd0, alu_a}, {28'd0, a_lat});
            chk({tag, "_exec_rsp"}, {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
            tick();
        end
        settle();
        chk({tag, "_rsp_valid"}, {30'd0, rsp1_valid, rsp0_valid}, (got == 1) ? 32'd2 : 32'd1);
        chk({tag, "_rsp_data"}, (got == 1) ? {27'd0, rsp1_cout, rsp1_o} : {27'd0, rsp0_cout, rsp0_o},
            {27'd0, res});
        chk({tag, "_rsp_en"}, {31'd0, alu_enable}, 32'd0);
    endtask

    initial begin
        int t0, t1;
        logic [4:0] r;
        bit inflight, m_last, m_id, e0, e1, ev0, ev1, a0, a1;
        int rsp_at, free_at;
        logic [4:0] m_res;

        reset = 1'b1;
        req0_a = 4'h1; req0_b = 4'h2; req0_c = 1'b0; req0_s = 3'd0;
        req1_a = 4'h9; req1_b = 4'h3; req1_c = 1'b1; req1_s = 3'd1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1; l3_valid = 1'b0;
        repeat (2) tick();
        settle();
        chk("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_en", {31'd0, alu_enable}, 32'd0);
        chk("rst_alu_ops", {24'd0, alu_a, alu_b}, 32'd0);
        chk("rst_rsp", {20'd0, rsp1_valid, rsp1_cout, rsp1_o, rsp0_valid, rsp0_cout, rsp0_o}, 32'd0);
        chk("rst_l3", {20'd0, l3_rsp1_valid, l3_rsp1_cout, l3_rsp1_o, l3_rsp0_valid, l3_rsp0_cout, l3_rsp0_o}, 32'd0);
        chk("rst_l3_ready", {30'd0, l3_r1rdy, l3_ready}, 32'd0);
        tick();
        reset = 1'b0;

        // Tie from reset: alternation starting with req0, ops 4 cycles apart.
        expect_op("tie0", 0, 1'b0, t0, r);
        tick();
        expect_op("tie1", 1, 1'b0, t1, r);
        chk("tie_gap1", t1 - t0, 4);
        tick();
        expect_op("tie2", 0, 1'b0, t0, r);
        chk("tie_gap2", t0 - t1, 4);
        tick();
        expect_op("tie3", 1, 1'b0, t1, r);
        chk("tie_gap3", t1 - t0, 4);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();

        // Single op: 3 + 5 = 8; requester changes its fields right after handshake.
        req0_a = 4'h3; req0_b = 4'h5; req0_c = 1'b0; req0_s = 3'b000; req0_valid = 1'b1;
        expect_op("single", 0, 1'b1, t0, r);
        chk("single_value", {27'd0, r}, 32'h08);
        tick();
        settle();
        chk("single_rsp_once", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        chk("single_idle", {31'd0, busy}, 32'd0);
        tick();

        // S hold: XOR A^6 = C, S flips after issue.
        req0_a = 4'hA; req0_b = 4'h6; req0_c = 1'b1; req0_s = 3'b100; req0_valid = 1'b1;
        expect_op("shold", 0, 1'b1, t0, r);
        chk("shold_value", {27'd0, r}, 32'h0C);
        tick();

        // Backpressure on requester 1 while requester 0 waits.
        rsp1_ready = 1'b0;
        req1_a = 4'h7; req1_b = 4'h2; req1_c = 1'b0; req1_s = 3'd1; req1_valid = 1'b1;
        expect_op("bp", 1, 1'b1, t0, r);
        req0_a = 4'h4; req0_b = 4'hC; req0_c = 1'b0; req0_s = 3'd0; req0_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            settle();
            chk("bp_hold_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd2);
            chk("bp_hold_data", {27'd0, rsp1_cout, rsp1_o}, {27'd0, r});
            chk("bp_en", {31'd0, alu_enable}, 32'd0);
            chk("bp_req0_ready", {31'd0, req0_ready}, 32'd0);
        end
        rsp1_ready = 1'b1;
        tick();
        settle();
        chk("bp_release_idle", {31'd0, busy}, 32'd0);
        chk("bp_release_rsp", {31'd0, rsp1_valid}, 32'd0);
        expect_op("post_bp", 0, 1'b1, t0, r);
        chk("post_bp_value", {27'd0, r}, 32'h10);
        tick();

        // Reset during EXEC drops the op and restores tie priority to req0.
        req0_a = 4'h2; req0_b = 4'h2; req0_c = 1'b0; req0_s = 3'd0; req0_valid = 1'b1;
        settle();
        chk("r5_hs", {31'd0, req0_ready}, 32'd1);
        tick();
        req0_valid = 1'b0;
        tick();
        settle();
        chk("r5_in_exec", {31'd0, alu_enable}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        chk("r5_busy", {31'd0, busy}, 32'd0);
        chk("r5_en", {31'd0, alu_enable}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            chk("r5_no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
            tick();
            settle();
        end
        tick();
        req0_valid = 1'b1; req1_valid = 1'b1;
        expect_op("r5_tie", 0, 1'b0, t0, r);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();

        // LATENCY=3 build: 15 + 1 + 1 = 0x11.
        req0_a = 4'hF; req0_b = 4'h1; req0_c = 1'b1; req0_s = 3'd0; l3_valid = 1'b1;
        settle();
        chk("l3_hs", {31'd0, l3_ready}, 32'd1);
        tick();
        l3_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("l3_en", {31'd0, l3_en}, (i < 3) ? 32'd1 : 32'd0);
            chk("l3_busy", {31'd0, l3_busy}, (i < 4) ? 32'd1 : 32'd0);
            chk("l3_rsp_valid", {30'd0, l3_rsp1_valid, l3_rsp0_valid}, (i == 3) ? 32'd1 : 32'd0);
            if (i == 3) chk("l3_rsp_data", {27'd0, l3_rsp0_cout, l3_rsp0_o}, 32'h11);
            tick();
        end

        // Randomized run against a transaction-level reference.
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        inflight = 1'b0; m_last = 1'b1; m_id = 1'b0; m_res = '0;
        rsp_at = 0; free_at = cyc; a0 = 1'b1; a1 = 1'b1;
        for (int k = 0; k < 400; k++) begin
            if (!req0_valid || a0) begin
                req0_valid = ($urandom_range(0, 2) != 0);
                req0_a = W'($urandom); req0_b = W'($urandom);
                req0_c = 1'($urandom); req0_s = 3'($urandom);
            end
            if (!req1_valid || a1) begin
                req1_valid = ($urandom_range(0, 2) != 0);
                req1_a = W'($urandom); req1_b = W'($urandom);
                req1_c = 1'($urandom); req1_s = 3'($urandom);
            end
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
            settle();
            e0  = !inflight && cyc >= free_at && req0_valid && (!req1_valid || m_last);
            e1  = !inflight && cyc >= free_at && req1_valid && (!req0_valid || !m_last);
            ev0 = inflight && !m_id && cyc >= rsp_at;
            ev1 = inflight && m_id && cyc >= rsp_at;
            chk("rnd_ready", {30'd0, req1_ready, req0_ready}, {30'd0, e1, e0});
            chk("rnd_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, {30'd0, ev1, ev0});
            chk("rnd_busy", {31'd0, busy}, {31'd0, inflight});
            chk("rnd_en", {31'd0, alu_enable}, {31'd0, inflight && cyc < rsp_at});
            if (ev0) chk("rnd_rsp0_data", {27'd0, rsp0_cout, rsp0_o}, {27'd0, m_res});
            if (ev1) chk("rnd_rsp1_data", {27'd0, rsp1_cout, rsp1_o}, {27'd0, m_res});
            a0 = e0;
            a1 = e1;
            if (e0 || e1) begin
                inflight = 1'b1;
                m_id     = e1;
                m_last   = e1;
                m_res    = e1 ? alu_f(req1_a, req1_b, req1_c, req1_s)
                              : alu_f(req0_a, req0_b, req0_c, req0_s);
                rsp_at   = cyc + 3;
            end else if ((ev0 && rsp0_ready) || (ev1 && rsp1_ready)) begin
                inflight = 1'b0;
                free_at  = cyc + 1;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
